// File: rtl/arb_requester.sv
// arb_requester: queues up to two burst jobs, requests the arbiter for each
// one, streams len+1 beats while granted, then idles for GAP cycles between
// jobs.
// Optional feature macro: ARB_REQ_TIMEOUT_EN. When it is defined, a job that
// waits TIMEOUT cycles in REQ without a grant is abandoned and the timeout
// output pulses.
module arb_requester #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] len,
    input  logic       gnt,
    output logic       req,
    output logic       beat_valid,
    output logic [3:0] beat_idx,
    output logic       done,
    output logic [1:0] pending,
    output logic       overflow
`ifdef ARB_REQ_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned GAP_W = 4;
`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = 8;
`endif

    // Reject parameter values outside the supported ranges at elaboration
    if (TIMEOUT < 2 || TIMEOUT > 255 || GAP < 1 || GAP > 15) begin : g_param_check
        $error("arb_requester: TIMEOUT must be 2..255 and GAP 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [LEN_W-1:0]   head_q;
    logic [LEN_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [LEN_W-1:0]   beat_q;
    logic [GAP_W-1:0]   gap_q;
    logic               req_q;
    logic               done_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic               last_beat;
`ifdef ARB_REQ_TIMEOUT_EN
    logic [WAIT_W-1:0]  wait_q;
    logic               timeout_q;
    logic               tmo_hit;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus queue push/pop decisions
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        last_beat = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        push      = start && (count_q != 2'd2);

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (gnt) begin
                    state_d = ST_XFER;
                end
`ifdef ARB_REQ_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_GAP;
                    pop     = 1'b1;
                    tmo_hit = 1'b1;
                end
`endif
            end
            ST_XFER: begin
                if (gnt && (beat_q == head_q)) begin
                    last_beat = 1'b1;
                    pop       = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry job queue: head is the active job, tail the next one
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) begin
                        head_q <= len;
                    end else begin
                        tail_q <= len;
                    end
                    count_q <= count_q + CNT_W'(1);
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_W'(1);
                end
                2'b11: begin
                    // Only possible with one entry: the new job becomes head
                    head_q <= len;
                end
                default: begin
                end
            endcase
            if (start && (count_q == 2'd2)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Beat counter, gap timer and registered pulses/request
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_q <= '0;
            gap_q  <= '0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if ((state_q == ST_REQ) && (state_d == ST_XFER)) begin
                beat_q <= '0;
            end else if ((state_q == ST_XFER) && gnt) begin
                beat_q <= last_beat ? '0 : beat_q + LEN_W'(1);
            end

            if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
                gap_q <= GAP_W'(GAP - 1);
            end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            req_q  <= (state_d == ST_REQ) || (state_d == ST_XFER);
            done_q <= last_beat;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    // Counts consecutive REQ cycles; restarts whenever REQ is left
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_REQ) begin
                wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end
            timeout_q <= tmo_hit;
        end
    end

    assign timeout = timeout_q;
`endif

    assign req        = req_q;
    assign beat_valid = (state_q == ST_XFER) && gnt;
    assign beat_idx   = beat_q;
    assign done       = done_q;
    assign pending    = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: a per-cycle vector table plus
// hand-written sequences for long waits (and timeout when enabled).
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       gnt;
    logic       req;
    logic       beat_valid;
    logic [3:0] beat_idx;
    logic       done;
    logic [1:0] pending;
    logic       overflow;
`ifdef ARB_REQ_TIMEOUT_EN
    logic       timeout;
`endif

    arb_requester #(.TIMEOUT(16), .GAP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .gnt        (gnt),
        .req        (req),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .done       (done),
        .pending    (pending),
        .overflow   (overflow)
`ifdef ARB_REQ_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [3:0] len;
        logic       gnt;
        logic       req;
        logic       bv;
        logic [3:0] idx;
        logic       done;
        logic [1:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vec[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic v(input logic r, input logic s, input logic [3:0] l, input logic g,
                     input logic e_req, input logic e_bv, input logic [3:0] e_idx,
                     input logic e_done, input logic [1:0] e_pend, input logic e_ovf);
        vec_t t;
        t.rst = r; t.start = s; t.len = l; t.gnt = g;
        t.req = e_req; t.bv = e_bv; t.idx = e_idx; t.done = e_done;
        t.pend = e_pend; t.ovf = e_ovf;
        vec.push_back(t);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and let outputs settle
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; gnt = 1'b0; len = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int cnt;
    int w;
    int beats;
    int dones;
    int bad;

    initial begin
        rst = 1'b0; start = 1'b0; gnt = 1'b0; len = '0;

        // len=3, gnt tied high
        v(1,1,3,1, 0,0,0,0,0,0);
        v(1,0,0,1, 0,0,0,0,1,0);
        v(1,0,0,1, 1,0,0,0,1,0);
        v(1,0,0,1, 1,1,0,0,1,0);
        v(1,0,0,1, 1,1,1,0,1,0);
        v(1,0,0,1, 1,1,2,0,1,0);
        v(1,0,0,1, 1,1,3,0,1,0);
        v(1,0,0,1, 0,0,0,1,0,0);
        v(1,0,0,1, 0,0,0,0,0,0);
        // len=5, grant paused for 3 cycles after beat 2
        v(1,1,5,1, 0,0,0,0,0,0);
        v(1,0,0,1, 0,0,0,0,1,0);
        v(1,0,0,1, 1,0,0,0,1,0);
        v(1,0,0,1, 1,1,0,0,1,0);
        v(1,0,0,1, 1,1,1,0,1,0);
        v(1,0,0,1, 1,1,2,0,1,0);
        v(1,0,0,0, 1,0,3,0,1,0);
        v(1,0,0,0, 1,0,3,0,1,0);
        v(1,0,0,0, 1,0,3,0,1,0);
        v(1,0,0,1, 1,1,3,0,1,0);
        v(1,0,0,1, 1,1,4,0,1,0);
        v(1,0,0,1, 1,1,5,0,1,0);
        v(1,0,0,1, 0,0,0,1,0,0);
        v(1,0,0,1, 0,0,0,0,0,0);
        // three back-to-back starts without grant: third is dropped
        v(1,1,2,0, 0,0,0,0,0,0);
        v(1,1,5,0, 0,0,0,0,1,0);
        v(1,1,9,0, 1,0,0,0,2,0);
        v(1,0,0,0, 1,0,0,0,2,1);
        v(1,0,0,1, 1,0,0,0,2,1);
        v(1,0,0,1, 1,1,0,0,2,1);
        v(1,0,0,1, 1,1,1,0,2,1);
        v(1,0,0,1, 1,1,2,0,2,1);
        v(1,0,0,1, 0,0,0,1,1,1);
        v(1,0,0,1, 0,0,0,0,1,1);
        v(1,0,0,1, 1,0,0,0,1,1);
        for (int i = 0; i < 6; i++) v(1,0,0,1, 1,1,4'(i),0,1,1);
        v(1,0,0,1, 0,0,0,1,0,1);
        v(1,0,0,1, 0,0,0,0,0,1);
        // len=7, reset during beat 2 with a coincident start
        v(1,1,7,1, 0,0,0,0,0,1);
        v(1,0,0,1, 0,0,0,0,1,1);
        v(1,0,0,1, 1,0,0,0,1,1);
        v(1,0,0,1, 1,1,0,0,1,1);
        v(1,0,0,1, 1,1,1,0,1,1);
        v(0,1,4,1, 1,1,2,0,1,1);
        v(1,0,0,1, 0,0,0,0,0,0);
        v(1,0,0,1, 0,0,0,0,0,0);
        // new job after reset; next job pushed on its last beat
        v(1,1,1,1, 0,0,0,0,0,0);
        v(1,0,0,1, 0,0,0,0,1,0);
        v(1,0,0,1, 1,0,0,0,1,0);
        v(1,0,0,1, 1,1,0,0,1,0);
        v(1,1,0,1, 1,1,1,0,1,0);
        v(1,0,0,1, 0,0,0,1,1,0);
        v(1,0,0,1, 0,0,0,0,1,0);
        v(1,0,0,1, 1,0,0,0,1,0);
        v(1,0,0,1, 1,1,0,0,1,0);
        v(1,0,0,1, 0,0,0,1,0,0);
        v(1,0,0,1, 0,0,0,0,0,0);

        repeat (2) @(posedge clk);

        foreach (vec[i]) begin
            @(negedge clk);
            rst = vec[i].rst; start = vec[i].start; len = vec[i].len; gnt = vec[i].gnt;
            #1;
            chk($sformatf("row%0d req", i),        8'(req),        8'(vec[i].req));
            chk($sformatf("row%0d beat_valid", i), 8'(beat_valid), 8'(vec[i].bv));
            chk($sformatf("row%0d beat_idx", i),   8'(beat_idx),   8'(vec[i].idx));
            chk($sformatf("row%0d done", i),       8'(done),       8'(vec[i].done));
            chk($sformatf("row%0d pending", i),    8'(pending),    8'(vec[i].pend));
            chk($sformatf("row%0d overflow", i),   8'(overflow),   8'(vec[i].ovf));
`ifdef ARB_REQ_TIMEOUT_EN
            chk($sformatf("row%0d timeout", i),    8'(timeout),    8'd0);
`endif
        end

`ifdef ARB_REQ_TIMEOUT_EN
        // No grant at all: job abandoned after 16 REQ cycles
        do_reset();
        start = 1'b1; len = 4'd3; gnt = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("tmo_req_rise", 8'(req), 8'd1);
        cnt = 0; w = 0; bad = 0;
        while (req && w < 40) begin
            if (timeout || done) bad++;
            cnt++;
            w++;
            tick();
        end
        chk("tmo_req_cycles", 8'(cnt), 8'd16);
        chk("tmo_early_pulse", 8'(bad), 8'd0);
        chk("tmo_pulse", 8'(timeout), 8'd1);
        chk("tmo_pending", 8'(pending), 8'd0);
        chk("tmo_no_done", 8'(done), 8'd0);
        tick();
        chk("tmo_single_pulse", 8'(timeout), 8'd0);
        chk("tmo_req_low", 8'(req), 8'd0);
        chk("tmo_no_done2", 8'(done), 8'd0);
`else
        // No grant for a long time: request held, then job completes
        do_reset();
        start = 1'b1; len = 4'd2; gnt = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("wait_req_rise", 8'(req), 8'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req && !done && !beat_valid && pending == 2'd1) cnt++;
        end
        chk("wait_req_held", 8'(cnt), 8'd40);
        gnt = 1'b1;
        beats = 0; dones = 0; w = 0; bad = 0;
        while (dones == 0 && w < 30) begin
            tick();
            w++;
            if (beat_valid) begin
                if (beat_idx != 4'(beats)) bad++;
                beats++;
            end
            if (done) dones++;
        end
        chk("wait_done_seen", 8'(dones), 8'd1);
        chk("wait_beats", 8'(beats), 8'd3);
        chk("wait_idx_order", 8'(bad), 8'd0);
        chk("wait_req_low", 8'(req), 8'd0);
        chk("wait_pending", 8'(pending), 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter: TIMEOUT, default 16, REQ-state cycles without grant before the job is abandoned; legal range 2..255.
REQ-002 Parameter: GAP, default 1, cycles req SHALL stay low between jobs; legal range 1..15.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle job request; enqueues len.
REQ-006 len  in  4  beats minus one for the job (0 -> 1 beat, 15 -> 16 beats).
REQ-007 gnt  in  1  grant from the arbiter.
REQ-008 req  out  1  request to the arbiter.
REQ-009 beat_valid  out  1  one data beat transferred this cycle.
REQ-010 beat_idx  out  4  index of the current beat within the job.
REQ-011 done  out  1  one-cycle pulse, job completed.
REQ-012 pending  out  2  jobs queued, including the active job (0..2).
REQ-013 overflow  out  1  sticky, start dropped while queue full.
REQ-014 timeout  out  1  one-cycle pulse, job abandoned (present only with macro, see Configuration).

Function
REQ-015 Job queue SHALL be a 2-entry FIFO of len values; start with pending<2 pushes; start with pending==2 SHALL be ignored and set overflow.
REQ-016 Push and pop in the same cycle SHALL leave pending unchanged and preserve order.
REQ-017 State machine SHALL have states IDLE, REQ, XFER, GAP; req SHALL be 1 exactly in REQ and XFER (Moore, registered state).
REQ-018 IDLE -> REQ on the edge where pending!=0; start sampled at edge N with empty queue SHALL give req=1 after edge N+1.
REQ-019 REQ -> XFER on the edge where gnt==1; beat counter cleared to 0.
REQ-020 In XFER, beat_valid SHALL equal gnt (combinational); beat_idx SHALL equal the beat counter; counter increments on each beat.
REQ-021 gnt low mid-burst SHALL pause the burst: beat_valid=0, counter held, req held 1, state stays XFER.
REQ-022 Beat with beat_idx==head len SHALL pop the queue and move to GAP; done SHALL be 1 for the first GAP cycle only.
REQ-023 GAP SHALL last GAP cycles, then go to IDLE; back-to-back jobs therefore see req low for GAP cycles minimum.
REQ-024 start is accepted in every state, including mid-burst; the active job's len SHALL not change.

Reset
REQ-025 rst==0 at an edge SHALL force state IDLE, queue empty, counters 0, req=0, done=0, pending=0, overflow=0, timeout=0, beat_idx=0.
REQ-026 Reset mid-burst SHALL drop req after that edge with no done pulse; start coincident with reset SHALL be discarded.

Configuration
REQ-027 Macro ARB_REQ_TIMEOUT_EN: when defined, a wait counter SHALL count REQ-state cycles; on the TIMEOUT-th cycle without gnt the job is popped, timeout pulses 1 cycle, state goes GAP, no done.
REQ-028 Without ARB_REQ_TIMEOUT_EN the timeout port and counter SHALL be absent and REQ SHALL wait for gnt indefinitely.

Verification
REQ-029 start, len=3, gnt tied 1 -> req rises 2 edges after start, beat_idx 0,1,2,3 on 4 consecutive beats, done 1 cycle, req low for GAP=1 cycle.
REQ-030 len=5, gnt dropped for 3 cycles after beat 2 -> beat_valid 0 for those 3 cycles, beat_idx resumes at 3, exactly 6 beats total, 1 done.
REQ-031 Three start pulses back-to-back while gnt=0 -> pending=2, overflow=1; after grant, exactly 2 jobs complete in order with their lens.
REQ-032 Macro defined, TIMEOUT=16, gnt never asserted -> timeout pulse on 16th REQ cycle, pending decrements, no done, req low for GAP cycles.
REQ-033 rst=0 during beat 2 of len=7 job -> outputs all 0 next cycle, pending=0, no done; new start afterwards completes normally.
